// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, decode handshake and redirect.
// master = fetch unit side, slave = memory/decode/branch side.
interface fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 64
);
  logic                  imem_req_valid_out;
  logic                  imem_req_ready_in;
  logic [ADDR_WIDTH-1:0] imem_req_addr_out;
  logic                  imem_resp_valid_in;
  logic [31:0]           imem_resp_instr_in;
  logic                  instr_valid_out;
  logic                  instr_ready_in;
  logic [31:0]           instr_out;
  logic [ADDR_WIDTH-1:0] instr_pc_out;
  logic                  redirect_in;
  logic [ADDR_WIDTH-1:0] redirect_addr_in;

  modport master (
    output imem_req_valid_out, imem_req_addr_out,
    output instr_valid_out, instr_out, instr_pc_out,
    input  imem_req_ready_in, imem_resp_valid_in, imem_resp_instr_in,
    input  instr_ready_in, redirect_in, redirect_addr_in
  );

  modport slave (
    input  imem_req_valid_out, imem_req_addr_out,
    input  instr_valid_out, instr_out, instr_pc_out,
    output imem_req_ready_in, imem_resp_valid_in, imem_resp_instr_in,
    output instr_ready_in, redirect_in, redirect_addr_in
  );
endinterface

// File: rtl/fetch_unit.sv
// Decoupled fetch stage: owns the fetch PC, issues in-order word requests, buffers responses
// with their PCs and flushes on redirect. Optional macro FETCH_BYPASS_EN: same-cycle delivery to an empty buffer.
module fetch_unit #(
  parameter int unsigned                     ADDR_WIDTH_POW = 6,
  parameter int unsigned                     FIFO_DEPTH_POW = 2,
  parameter logic [(1<<ADDR_WIDTH_POW)-1:0] RESET_PC       = '0
) (
  input  logic         clk_in,
  input  logic         reset,
  fetch_unit_if.master bus
);
  localparam int unsigned AW    = 1 << ADDR_WIDTH_POW;
  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_POW;
  localparam int unsigned PW    = FIFO_DEPTH_POW;
  localparam int unsigned CW    = FIFO_DEPTH_POW + 1;

  logic [AW-1:0] r_pc;
  logic [31:0]   r_fifo_instr [DEPTH];
  logic [AW-1:0] r_fifo_pc    [DEPTH];
  logic [AW-1:0] r_tag        [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr, r_tag_wr, r_tag_rd;
  logic [CW-1:0] r_count, r_outstanding, r_drop;

  logic          w_has_room, w_req_valid, w_req_fire, w_tag_write;
  logic          w_resp, w_resp_keep, w_fifo_empty;
  logic          w_bypass, w_bypass_take, w_push, w_pop;
  logic [CW:0]   w_in_use;
  logic [CW-1:0] w_outstanding_next;

  // Buffered plus in-flight never exceeds the depth, so every response is guaranteed a slot.
  assign w_in_use     = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_has_room   = w_in_use < (CW+1)'(DEPTH);
  assign w_req_valid  = reset && w_has_room;
  assign w_req_fire   = w_req_valid && bus.imem_req_ready_in;
  assign w_tag_write  = w_has_room && bus.imem_req_ready_in;

  // A response with nothing outstanding (e.g. left over from before a reset) is ignored.
  assign w_resp       = bus.imem_resp_valid_in && (r_outstanding != '0);
  assign w_resp_keep  = w_resp && (r_drop == '0) && !bus.redirect_in;
  assign w_fifo_empty = (r_count == '0);

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_resp_keep && w_fifo_empty;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_bypass_take = w_bypass && bus.instr_ready_in;
  assign w_pop         = !w_fifo_empty && bus.instr_ready_in;
  assign w_push        = w_resp_keep && !w_bypass_take;

  always_comb begin
    // NOTE: assign a default before any condition so the block can never infer a latch.
    w_outstanding_next = r_outstanding;
    if (w_req_fire) w_outstanding_next = w_outstanding_next + CW'(1);
    if (w_resp)     w_outstanding_next = w_outstanding_next - CW'(1);
  end

  assign bus.imem_req_valid_out = w_req_valid;
  assign bus.imem_req_addr_out  = r_pc;
  assign bus.instr_valid_out    = !w_fifo_empty || w_bypass;
  assign bus.instr_out          = w_bypass ? bus.imem_resp_instr_in : r_fifo_instr[r_rd_ptr];
  assign bus.instr_pc_out       = w_bypass ? r_tag[r_tag_rd]        : r_fifo_pc[r_rd_ptr];

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_pc          <= RESET_PC;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_tag_wr      <= '0;
      r_tag_rd      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
      if (w_req_fire) r_tag_wr <= r_tag_wr + PW'(1);
      if (w_resp)     r_tag_rd <= r_tag_rd + PW'(1);
      if (bus.redirect_in) begin
        // Everything still in flight after this edge belongs to the old stream.
        r_pc     <= bus.redirect_addr_in & ~AW'(3);
        r_drop   <= w_outstanding_next;
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_req_fire)               r_pc     <= r_pc + AW'(4);
        if (w_resp && r_drop != '0)   r_drop   <= r_drop - CW'(1);
        if (w_push)                   r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)                    r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // NOTE: storage arrays are not reset; an entry is only read after it has been written.
  always_ff @(posedge clk_in) begin
    if (w_tag_write) r_tag[r_tag_wr] <= r_pc;
    if (w_push) begin
      r_fifo_instr[r_wr_ptr] <= bus.imem_resp_instr_in;
      r_fifo_pc[r_wr_ptr]    <= r_tag[r_tag_rd];
    end
  end
endmodule
